// File: rtl/addsub_pkg.sv
// addsub_pkg: op encoding plus clog2 and pipeline-latency helpers shared by the adder and its bench
package addsub_pkg;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_SLTU = 2'b10, OP_SLT = 2'b11} op_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; (1 << i) < v; i++) r = i + 1;
        return r;
    endfunction
    function automatic int addsub_latency(input int w, input int lps);
        return 1 + (clog2(w) + lps - 1) / lps;
    endfunction
endpackage

// File: rtl/addsub_prefix_pipe_level.sv
// prefix_pg_level: one Sklansky level, g_i/p_i group generate/propagate in, g_o/p_o out; levels past clog2(WIDTH) pass through
module prefix_pg_level #(
    parameter int WIDTH = 32,
    parameter int LEVEL = 0
) (
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] g_o,
    output logic [WIDTH-1:0] p_o
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_b
        if (((i >> LEVEL) & 1) == 1) begin : g_c
            localparam int J = ((i >> LEVEL) << LEVEL) - 1;
            assign g_o[i] = g_i[i] | (p_i[i] & g_i[J]);
            assign p_o[i] = p_i[i] & p_i[J];
        end else begin : g_n
            assign g_o[i] = g_i[i];
            assign p_o[i] = p_i[i];
        end
    end
endmodule

// File: rtl/addsub_prefix_pipe.sv
// addsub_prefix_pipe: pipelined prefix add/sub/compare; in_valid/in_ready/op/a/b/cin/tag_in in, out_valid/out_ready/result/cout/overflow/zero/tag_out out
module addsub_prefix_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAG_W            = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic [TAG_W-1:0] tag_out
);
    localparam int LPS = LEVELS_PER_STAGE;
    localparam int NS  = addsub_latency(WIDTH, LPS) - 1;
    logic             rdy_q;
    logic             v_q   [NS];
    logic [WIDTH-1:0] g_q   [NS];
    logic [WIDTH-1:0] p_q   [NS];
    logic [WIDTH-1:0] x_q   [NS];
    logic             c_q   [NS];
    op_t              op_q  [NS];
    logic [TAG_W-1:0] tag_q [NS];
    logic [WIDTH-1:0] gn    [NS];
    logic [WIDTH-1:0] pn    [NS];
    logic             out_valid_q, cout_q, overflow_q, zero_q;
    logic [WIDTH-1:0] result_q;
    logic [TAG_W-1:0] tag_out_q;
    logic             adv, sub_d, c_d, co_d, ov_d, arith_d, unused_p;
    op_t              op_d, op_l;
    logic [WIDTH-1:0] bx_d, p_d, g_d, gf, sum_d, res_d;
    assign adv      = !(out_valid_q && !out_ready);
    assign in_ready = rdy_q && adv;
    assign op_d     = op_t'(op);
    assign sub_d    = op_d != OP_ADD;
    assign bx_d     = sub_d ? ~b : b;
    assign c_d      = sub_d ? 1'b1 : cin;
    assign p_d      = a ^ bx_d;
    // Fold the carry-in into bit 0's generate so the prefix G at bit i is the carry out of bit i.
    assign g_d      = (a & bx_d) | {{(WIDTH-1){1'b0}}, p_d[0] & c_d};
    for (genvar s = 0; s < NS; s++) begin : g_st
        logic [WIDTH-1:0] gc [LPS+1];
        logic [WIDTH-1:0] pc [LPS+1];
        assign gc[0] = g_q[s];
        assign pc[0] = p_q[s];
        for (genvar l = 0; l < LPS; l++) begin : g_lv
            prefix_pg_level #(.WIDTH(WIDTH), .LEVEL(s * LPS + l)) u_lvl (
                .g_i(gc[l]), .p_i(pc[l]), .g_o(gc[l+1]), .p_o(pc[l+1])
            );
        end
        assign gn[s] = gc[LPS];
        assign pn[s] = pc[LPS];
    end
    assign unused_p = ^pn[NS-1];
    assign gf       = gn[NS-1];
    assign op_l     = op_q[NS-1];
    assign sum_d    = x_q[NS-1] ^ {gf[WIDTH-2:0], c_q[NS-1]};
    assign co_d     = gf[WIDTH-1];
    assign ov_d     = gf[WIDTH-1] ^ gf[WIDTH-2];
    assign arith_d  = op_l == OP_ADD || op_l == OP_SUB;
    assign res_d    = arith_d ? sum_d
                    : {{(WIDTH-1){1'b0}}, op_l == OP_SLTU ? !co_d : sum_d[WIDTH-1] ^ ov_d};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q       <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            tag_out_q   <= '0;
            for (int s = 0; s < NS; s++) begin
                v_q[s]   <= 1'b0;
                g_q[s]   <= '0;
                p_q[s]   <= '0;
                x_q[s]   <= '0;
                c_q[s]   <= 1'b0;
                op_q[s]  <= OP_ADD;
                tag_q[s] <= '0;
            end
        end else begin
            rdy_q <= 1'b1;
            if (adv) begin
                v_q[0]   <= in_valid && in_ready;
                g_q[0]   <= g_d;
                p_q[0]   <= p_d;
                x_q[0]   <= p_d;
                c_q[0]   <= c_d;
                op_q[0]  <= op_d;
                tag_q[0] <= tag_in;
                for (int s = 1; s < NS; s++) begin
                    v_q[s]   <= v_q[s-1];
                    g_q[s]   <= gn[s-1];
                    p_q[s]   <= pn[s-1];
                    x_q[s]   <= x_q[s-1];
                    c_q[s]   <= c_q[s-1];
                    op_q[s]  <= op_q[s-1];
                    tag_q[s] <= tag_q[s-1];
                end
                out_valid_q <= v_q[NS-1];
                if (v_q[NS-1]) begin
                    result_q   <= res_d;
                    cout_q     <= co_d;
                    overflow_q <= arith_d && ov_d;
                    zero_q     <= res_d == '0;
                    tag_out_q  <= tag_q[NS-1];
                end
            end
        end
    end
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign tag_out   = tag_out_q;
endmodule
